// File: rtl/g726_pkg.sv
// ---------------------------------------------------------------------------
// g726_pkg
// Shared constants, FSM state encoding and the A1 scaling helper used by the
// a2 coefficient update datapath.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package g726_pkg;

  // Datapath widths: 16-bit coefficients, 17-bit gradient arithmetic.
  localparam int unsigned C_W16 = 16;
  localparam int unsigned C_W17 = 17;

  // a2 limits: +0.75 and -0.75 in Q14 two's complement.
  localparam logic [C_W16-1:0] C_A2UL = 16'd12288;
  localparam logic [C_W16-1:0] C_A2LL = 16'd53248;

  // Update sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } state_e;

  // A1 scaled by 4 into 17 bits, clamped to +/-8191 before scaling.
  function automatic logic [C_W17-1:0] a1_scale(input logic [C_W16-1:0] a1);
    logic [C_W17-1:0] s;
    if (a1[15]) begin
      s = (a1 >= 16'd57345) ? {a1[14:0], 2'b00} : 17'd98308;
    end else begin
      s = (a1 <= 16'd8191) ? {a1[14:0], 2'b00} : 17'd32764;
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/a2_coeff_update_limc.sv
// ---------------------------------------------------------------------------
// a2_coeff_update_limc
// Combinational a2 limiter: clamps the unlimited coefficient A2T into
// [A2LL, A2UL] in two's complement.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module a2_coeff_update_limc
  import g726_pkg::*;
#(
  parameter logic [C_W16-1:0] A2UL = C_A2UL,
  parameter logic [C_W16-1:0] A2LL = C_A2LL
) (
  input  logic [C_W16-1:0] a2t_i,
  output logic [C_W16-1:0] a2p_o
);

  // Negative values below A2LL clamp up, positive values above A2UL clamp down.
  always_comb begin
    a2p_o = a2t_i;
    if ((a2t_i >= 16'h8000) && (a2t_i < A2LL)) begin
      a2p_o = A2LL;
    end else if ((a2t_i > A2UL) && (a2t_i < 16'h8000)) begin
      a2p_o = A2UL;
    end
  end

endmodule

`default_nettype wire

// File: rtl/a2_coeff_update.sv
// ---------------------------------------------------------------------------
// a2_coeff_update
// Per-sample a2 pole coefficient update: gradient term, leakage term, limiter
// and transition-forced reset of the stored coefficient. Sequenced over three
// compute cycles plus a done cycle by a start/done handshake.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module a2_coeff_update
  import g726_pkg::*;
#(
  parameter logic [C_W16-1:0] A2UL = C_A2UL,
  parameter logic [C_W16-1:0] A2LL = C_A2LL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_in0,
  input  logic             scan_in1,
  input  logic             scan_in2,
  input  logic             scan_in3,
  input  logic             scan_in4,
  input  logic             scan_enable,
  input  logic             test_mode,
  input  logic             start,
  input  logic             PK0,
  input  logic             PK1,
  input  logic             PK2,
  input  logic             SIGPK,
  input  logic [C_W16-1:0] A1,
  input  logic             TR,
  output logic             busy,
  output logic             done,
  output logic [C_W16-1:0] A2P,
  output logic [C_W16-1:0] A2,
  output logic             scan_out0,
  output logic             scan_out1,
  output logic             scan_out2,
  output logic             scan_out3,
  output logic             scan_out4
);

  state_e           state_q;
  logic             busy_q, done_q;
  logic             pk0_q, pk1_q, pk2_q, sigpk_q, tr_q;
  logic [C_W16-1:0] a1_q;
  logic [C_W17-1:0] uga2a_q, fa_q;
  logic [C_W16-1:0] uga2_q, ula2_q;
  logic [C_W16-1:0] a2p_q, a2_q;

  logic             pks1, pks2;
  logic [C_W17-1:0] a1s, uga2a_d, fa_d, uga2b;
  logic [C_W16-1:0] uga2_d, ula2_d, a2_sh, ua2, a2t, a2p_w;

  // Stage datapaths; each stage consumes only registers loaded by the previous one.
  always_comb begin
    pks1    = pk0_q ^ pk1_q;
    pks2    = pk0_q ^ pk2_q;
    uga2a_d = pks2 ? 17'd114688 : 17'd16384;
    a1s     = a1_scale(a1_q);
    fa_d    = pks1 ? a1s : (17'd0 - a1s);
    uga2b   = uga2a_q + fa_q;
    if (sigpk_q) begin
      uga2_d = '0;
    end else if (uga2b[16]) begin
      uga2_d = {6'b0, uga2b[16:7]} + 16'd64512;
    end else begin
      uga2_d = {6'b0, uga2b[16:7]};
    end
    a2_sh  = {7'b0, a2_q[15:7]};
    ula2_d = a2_q[15] ? (16'd0 - (a2_sh + 16'd65024)) : (16'd0 - a2_sh);
    ua2    = uga2_q + ula2_q;
    a2t    = a2_q + ua2;
  end

  a2_coeff_update_limc #(
    .A2UL (A2UL),
    .A2LL (A2LL)
  ) u_limc (
    .a2t_i (a2t),
    .a2p_o (a2p_w)
  );

  // Sequencer with registered handshake outputs and all pipeline state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pk0_q   <= 1'b0;
      pk1_q   <= 1'b0;
      pk2_q   <= 1'b0;
      sigpk_q <= 1'b0;
      tr_q    <= 1'b0;
      a1_q    <= '0;
      uga2a_q <= '0;
      fa_q    <= '0;
      uga2_q  <= '0;
      ula2_q  <= '0;
      a2p_q   <= '0;
      a2_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            pk0_q   <= PK0;
            pk1_q   <= PK1;
            pk2_q   <= PK2;
            sigpk_q <= SIGPK;
            tr_q    <= TR;
            a1_q    <= A1;
            busy_q  <= 1'b1;
            state_q <= S1;
          end
        end
        S1: begin
          uga2a_q <= uga2a_d;
          fa_q    <= fa_d;
          state_q <= S2;
        end
        S2: begin
          uga2_q  <= uga2_d;
          ula2_q  <= ula2_d;
          state_q <= S3;
        end
        S3: begin
          a2p_q   <= a2p_w;
          a2_q    <= tr_q ? '0 : a2p_w;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign A2P  = a2p_q;
  assign A2   = a2_q;

  // Scan ports are stitched at DFT insertion; held low in functional mode.
  assign scan_out0 = test_mode & scan_enable & scan_in0;
  assign scan_out1 = test_mode & scan_enable & scan_in1;
  assign scan_out2 = test_mode & scan_enable & scan_in2;
  assign scan_out3 = test_mode & scan_enable & scan_in3;
  assign scan_out4 = test_mode & scan_enable & scan_in4;

endmodule

`default_nettype wire
